alu_logic_pipe: RTL
===================

# alu_logic_pipe

Parametrised, pipelined bitwise logic unit for the ALU. Generalises the 64-bit two-input AND to a configurable width with eight selectable logic operations. It sits between issue and writeback and carries results through a two-stage valid/ready pipeline, so downstream stalls hold results without loss. It sustains one operation per cycle when unstalled.

## Interface
- `WIDTH`, default 64: operand/result width in bits; must be ≥ 2.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous, active-low reset, sampled on `clk` rising edge.
- `in_valid`  in  1  operands/op presented.
- `in_ready`  out  1  unit accepts on this cycle; transfer occurs when `in_valid && in_ready`.
- `a`  in  WIDTH  operand A.
- `b`  in  WIDTH  operand B.
- `op`  in  3  operation select.
- `out_valid`  out  1  result presented.
- `out_ready`  in  1  consumer accepts; transfer occurs when `out_valid && out_ready`.
- `y`  out  WIDTH  result.
- `zero`  out  1  `y == 0`. Present only with `ALU_LOGIC_FLAGS_EN`.
- `parity`  out  1  XOR-reduction of `y`. Present only with `ALU_LOGIC_FLAGS_EN`.

## Operation
- `op` encoding:
  - 000 AND `a&b`
  - 001 OR `a|b`
  - 010 XOR `a^b`
  - 011 ANDN `a&~b`
  - 100 ORN `a|~b`
  - 101 XNOR `~(a^b)`
  - 110 PASS `a`
  - 111 NOT `~a`
- All ops are bitwise over full WIDTH; no carries, no width change.
- Stage 1 (S1) registers `a`, `b`, `op` and `s1_valid`.
- Stage 2 (S2) registers the computed `y`, the flags, and `s2_valid`. `out_valid = s2_valid`.
- `s2_load = !s2_valid || out_ready`.
- `s1_adv = s1_valid && s2_load`. S2 captures S1's result when `s1_adv`; otherwise, if `out_ready && s2_valid`, `s2_valid` clears.
- `in_ready = !s1_valid || s2_load`. S1 captures the input on `in_valid && in_ready`; otherwise, if `s1_adv`, `s1_valid` clears.
- `in_ready` depends combinationally on `out_ready`; no other combinational input-to-output path exists.
- Stall (`out_ready`=0, both stages full): `y`, flags, S1 contents and `op` hold stable; `in_ready`=0.
- Ordering: results leave in strict acceptance order; no drop, no duplication.
- Reset (`rst_n`=0 at an edge), also mid-operation:
  - `s1_valid`, `s2_valid` cleared; in-flight operations discarded.
  - `y`=0, `zero`=1, `parity`=0, `out_valid`=0.
  - `in_ready`=1 from the first cycle after reset.
- Inputs are ignored while `in_ready`=0. Data inputs may be X when `in_valid`=0 and must not propagate into `y` state.

## Timing
- Latency: input accepted at edge N → `out_valid`=1 with its `y` after edge N+1, i.e. visible 2 cycles after presentation.
- Throughput: 1 op/cycle with `out_ready` held 1.
- Capacity: 2 operations in flight. With `out_ready`=0, a third `in_valid` sees `in_ready`=0.
- Simultaneous accept and drain at the same edge with both stages full: both transfers occur and occupancy stays 2.
- After a full stall releases (`out_ready` 0→1), the held results drain on consecutive cycles.

## Configuration
- `ALU_LOGIC_FLAGS_EN` defined:
  - `zero` and `parity` ports exist.
  - Both are computed from the S1 result and registered in S2 alongside `y`, with identical latency and stall behaviour.
- `ALU_LOGIC_FLAGS_EN` undefined:
  - Ports and their logic are absent.
  - Data path, handshake and latency are unchanged.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with `in_valid`=1 → `out_valid`=0, `y`=0, `zero`=1, `parity`=0. After release, `in_ready`=1.
- All ops, WIDTH=64, `a`=0x0123456789ABCDEF, `b`=0xFEDCBA9876543210, `out_ready`=1, ops 000..111 back-to-back → eight results in order, 2-cycle latency, each matching the bitwise reference (AND=0x0000000000000000, OR=0xFFFFFFFFFFFFFFFF, XNOR=0x0000000000000000).
- Backpressure: `out_ready`=0, issue AND of 0xFFFFFFFFFFFFFFFF/0x0F0F0F0F0F0F0F0F, then 0xAAAA…AA/0x5555…55, then a third op → `in_ready`=0 on the third op.
  - `y`=0x0F0F0F0F0F0F0F0F held stable.
  - Raising `out_ready` drains 0x0F0F…0F then 0x0, then accepts the third op.
- Simultaneous accept/drain: both stages full, `in_valid`=`out_ready`=1 for 10 cycles with random data → 10 in-order results, no gaps, no drops.
- Flags (`ALU_LOGIC_FLAGS_EN`): XOR `a`=`b`=0x1234567890ABCDEF → `y`=0, `zero`=1, `parity`=0. PASS `a`=0x1 → `zero`=0, `parity`=1.
- Mid-operation reset: two ops in flight under stall, assert `rst_n`=0 for one cycle → no stale `out_valid`. The next accepted op emerges alone after 2 cycles.

Source files
------------

// File: rtl/alu_logic_pipe.sv
// alu_logic_pipe: two-stage valid/ready bitwise logic unit with eight ops.
// Define ALU_LOGIC_FLAGS_EN to add the registered zero/parity result flags.
module alu_logic_pipe #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y
`ifdef ALU_LOGIC_FLAGS_EN
    ,
    output logic             zero,
    output logic             parity
`endif
);
    logic             s1_valid;
    logic             s2_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [2:0]       s1_op;
    logic [WIDTH-1:0] res;
    logic             s2_load;
    logic             s1_adv;
    logic             in_fire;

    assign s2_load   = !s2_valid || out_ready;
    assign s1_adv    = s1_valid && s2_load;
    assign in_ready  = !s1_valid || s2_load;
    assign in_fire   = in_valid && in_ready;
    assign out_valid = s2_valid;

    always_comb begin
        res = s1_op == 3'd0 ? s1_a & s1_b    :
              s1_op == 3'd1 ? s1_a | s1_b    :
              s1_op == 3'd2 ? s1_a ^ s1_b    :
              s1_op == 3'd3 ? s1_a & ~s1_b   :
              s1_op == 3'd4 ? s1_a | ~s1_b   :
              s1_op == 3'd5 ? ~(s1_a ^ s1_b) :
              s1_op == 3'd6 ? s1_a           :
                              ~s1_a;
    end

    // Operand registers load only on an accepted transfer, so idle X inputs never enter state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= '0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_a     <= a;
            s1_b     <= b;
            s1_op    <= op;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            y        <= '0;
        end else if (s1_adv) begin
            s2_valid <= 1'b1;
            y        <= res;
        end else if (out_ready) begin
            s2_valid <= 1'b0;
        end
    end

`ifdef ALU_LOGIC_FLAGS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            zero   <= 1'b1;
            parity <= 1'b0;
        end else if (s1_adv) begin
            zero   <= ~|res;
            parity <= ^res;
        end
    end
`endif
endmodule
